do_buf: RTL and testbench

- Data-out staging buffer that sits directly upstream of the memory controller.
- Accepts words and bank tags from the producer over a valid/ready interface and queues them in a small FIFO.
- Presents the head entry to the memory controller over the do_rdy/do_acpt handshake.
- Holds memsel stable after each accept for the controller's post-accept sequence, so the controller always sees a constant bank select.

---
 rtl/do_buf_pkg.sv | 14 +
 rtl/do_buf_fifo.sv | 43 ++++
 rtl/do_buf.sv | 132 +++++++++++++
 tb/tb_do_buf.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/do_buf_pkg.sv
// Shared types and constants for the do_buf data-out staging buffer.
// The optional DO_BUF_PARITY_EN feature needs nothing from this package.
package do_buf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int unsigned SEL_W        = 2;
    localparam int unsigned HOLD_CYC_DEF = 7;

endpackage

// File: rtl/do_buf_fifo.sv
// Storage, pointers and occupancy for do_buf. Each pointer carries one extra
// wrap bit, so their difference is a DEPTH-inclusive level.
module do_buf_fifo #(
    parameter int unsigned EW    = 10,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [EW-1:0] wdata,
    input  logic          pop,
    output logic [EW-1:0] rdata,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // Entries are not reset: nothing reads them until level makes them valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign level = wptr - rptr;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/do_buf.sv
// Data-out staging buffer in front of the memory controller: FIFO plus an
// OFFER/HOLD handshake FSM. Define DO_BUF_PARITY_EN to add stored parity (do_par).
module do_buf
    import do_buf_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic                     do_rdy,
    input  logic                     do_acpt,
    output logic [DW-1:0]            do_data,
    output logic [SEL_W-1:0]         memsel,
    output logic [$clog2(DEPTH):0]   level,
`ifdef DO_BUF_PARITY_EN
    output logic                     do_par,
`endif
    output logic                     err_acpt
);

`ifdef DO_BUF_PARITY_EN
    localparam int unsigned EW = DW + SEL_W + 1;
`else
    localparam int unsigned EW = DW + SEL_W;
`endif
    localparam logic [3:0] CNT_LOAD = 4'(HOLD_CYC - 1);

    state_t           state;
    logic [3:0]       cnt;
    logic [SEL_W-1:0] hold_sel;
    logic [EW-1:0]    wdata;
    logic [EW-1:0]    head;
    logic [DW-1:0]    head_data;
    logic [SEL_W-1:0] head_sel;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

`ifdef DO_BUF_PARITY_EN
    assign wdata = {^in_data, in_sel, in_data};
`else
    assign wdata = {in_sel, in_data};
`endif
    assign head_data = head[DW-1:0];
    assign head_sel  = head[DW +: SEL_W];

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == OFFER) && do_acpt;

    do_buf_fifo #(
        .EW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            hold_sel <= '0;
            do_rdy   <= 1'b0;
            do_data  <= '0;
            memsel   <= '0;
            err_acpt <= 1'b0;
`ifdef DO_BUF_PARITY_EN
            do_par   <= 1'b0;
`endif
        end else begin
            if (do_acpt && state != OFFER) err_acpt <= 1'b1;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state   <= OFFER;
                        do_rdy  <= 1'b1;
                        do_data <= head_data;
                        memsel  <= head_sel;
`ifdef DO_BUF_PARITY_EN
                        do_par  <= head[EW-1];
`endif
                    end
                end
                OFFER: begin
                    if (do_acpt) begin
                        state    <= HOLD;
                        do_rdy   <= 1'b0;
                        hold_sel <= head_sel;
                        memsel   <= head_sel;
                        cnt      <= CNT_LOAD;
                    end
                end
                HOLD: begin
                    // Head already advanced at the accept, so it is the next entry here.
                    if (cnt == '0) begin
                        if (!empty) begin
                            state   <= OFFER;
                            do_rdy  <= 1'b1;
                            do_data <= head_data;
                            memsel  <= head_sel;
`ifdef DO_BUF_PARITY_EN
                            do_par  <= head[EW-1];
`endif
                        end else begin
                            state  <= IDLE;
                            memsel <= hold_sel;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_do_buf.sv
// Scoreboard bench for do_buf: producer words are queued when taken and
// compared against do_data/memsel at each accepted offer.
module tb_do_buf;
    import do_buf_pkg::*;

    localparam int unsigned DW       = 8;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned HOLD_CYC = 7;

    logic       clk      = 1'b0;
    logic       rstn     = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data  = '0;
    logic [1:0] in_sel   = '0;
    logic       do_rdy;
    logic       do_acpt  = 1'b0;
    logic [7:0] do_data;
    logic [1:0] memsel;
    logic [2:0] level;
    logic       err_acpt;
`ifdef DO_BUF_PARITY_EN
    logic       do_par;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    logic [9:0] sb [$];
    logic [9:0] exp_e;

    always #5 clk = ~clk;

    do_buf #(
        .DW       (DW),
        .DEPTH    (DEPTH),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .do_rdy   (do_rdy),
        .do_acpt  (do_acpt),
        .do_data  (do_data),
        .memsel   (memsel),
        .level    (level),
`ifdef DO_BUF_PARITY_EN
        .do_par   (do_par),
`endif
        .err_acpt (err_acpt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d, input logic [1:0] s);
        int   budget;
        logic taken;
        budget   = 50;
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        do begin
            taken = in_ready;
            tick();
            budget--;
        end while (!taken && budget > 0);
        in_valid = 1'b0;
        check_val("push_taken", taken, 1);
    endtask

    task automatic wait_rdy(output int gap);
        gap = 0;
        while (!do_rdy && gap < 40) begin
            tick();
            gap++;
        end
        check_val("rdy_seen", do_rdy, 1);
    endtask

    task automatic accept();
        do_acpt = 1'b1;
        tick();
        do_acpt = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_level"}, level, 0);
        check_val({tag, "_in_ready"}, in_ready, 1);
        check_val({tag, "_do_rdy"}, do_rdy, 0);
        check_val({tag, "_do_data"}, do_data, 0);
        check_val({tag, "_memsel"}, memsel, 0);
        check_val({tag, "_err"}, err_acpt, 0);
        check_val({tag, "_state"}, dut.state, IDLE);
        check_val({tag, "_cnt"}, dut.cnt, 0);
`ifdef DO_BUF_PARITY_EN
        check_val({tag, "_do_par"}, do_par, 0);
`endif
    endtask

    // Inputs change just after posedge, so the negedge sees what the next edge will act on.
    always @(negedge clk) begin
        if (rstn) begin
            if (in_valid && in_ready) sb.push_back({in_sel, in_data});
            if (do_rdy && do_acpt) begin
                check_val("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_e = sb.pop_front();
                    check_val("sb_do_data", do_data, exp_e[7:0]);
                    check_val("sb_memsel", memsel, exp_e[9:8]);
`ifdef DO_BUF_PARITY_EN
                    check_val("sb_do_par", do_par, ^exp_e[7:0]);
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;

        tick();
        tick();
        check_reset_outputs("reset");
        rstn = 1'b1;
        tick();

        // Single word: offer latency and hold window.
        push_word(8'hA5, 2'b10);
        check_val("t1_level", level, 1);
        check_val("t1_rdy_early", do_rdy, 0);
        tick();
        check_val("t1_rdy", do_rdy, 1);
        check_val("t1_data", do_data, 8'hA5);
        check_val("t1_memsel", memsel, 2'b10);
        accept();
        check_val("t1_rdy_drop", do_rdy, 0);
        check_val("t1_hold", dut.state, HOLD);
        check_val("t1_level0", level, 0);
        for (int i = 1; i < int'(HOLD_CYC); i++) begin
            tick();
            check_val("t1_hold_state", dut.state, HOLD);
            check_val("t1_hold_memsel", memsel, 2'b10);
        end
        tick();
        check_val("t1_idle", dut.state, IDLE);
        check_val("t1_idle_memsel", memsel, 2'b10);

        // Fill to full, refused fifth word, then drain.
        for (int i = 0; i < 4; i++) push_word(8'h10 + 8'(i), 2'(i));
        check_val("t2_level_full", level, 4);
        check_val("t2_ready_full", in_ready, 0);
        in_data  = 8'hEE;
        in_sel   = 2'b11;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_val("t2_level_still4", level, 4);
        check_val("t2_head_data", do_data, 8'h10);
        check_val("t2_head_sel", memsel, 2'b00);
        accept();
        check_val("t2_level3", level, 3);
        check_val("t2_ready3", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            wait_rdy(g);
            accept();
        end
        repeat (HOLD_CYC) tick();
        check_val("t2_idle", dut.state, IDLE);

        // Streaming across pointer wrap with accept right after each offer.
        fork
            begin
                for (int i = 0; i < 6; i++) push_word(8'h40 + 8'(i), 2'(i));
            end
            begin
                int gap;
                for (int k = 0; k < 6; k++) begin
                    wait_rdy(gap);
                    if (k > 0) check_val("t3_offer_gap", gap, HOLD_CYC);
                    accept();
                end
            end
        join
        repeat (HOLD_CYC) tick();
        check_val("t3_idle", dut.state, IDLE);
        check_val("t3_level0", level, 0);

        // Simultaneous push and pop at level 2.
        push_word(8'h61, 2'b01);
        push_word(8'h62, 2'b10);
        check_val("t4_level2", level, 2);
        check_val("t4_offer", dut.state, OFFER);
        in_data  = 8'h63;
        in_sel   = 2'b11;
        in_valid = 1'b1;
        do_acpt  = 1'b1;
        tick();
        in_valid = 1'b0;
        do_acpt  = 1'b0;
        check_val("t4_level_same", level, 2);
        for (int i = 0; i < 2; i++) begin
            wait_rdy(g);
            accept();
        end
        repeat (HOLD_CYC) tick();
        check_val("t4_idle", dut.state, IDLE);

        // Stray accepts in IDLE and in HOLD.
        check_val("t5_err_clear", err_acpt, 0);
        do_acpt = 1'b1;
        tick();
        do_acpt = 1'b0;
        check_val("t5_err_idle", err_acpt, 1);
        check_val("t5_state_idle", dut.state, IDLE);
        check_val("t5_level_idle", level, 0);
        push_word(8'h77, 2'b01);
        wait_rdy(g);
        accept();
        check_val("t5_in_hold", dut.state, HOLD);
        do_acpt = 1'b1;
        tick();
        do_acpt = 1'b0;
        check_val("t5_err_hold", err_acpt, 1);
        check_val("t5_state_hold", dut.state, HOLD);
        check_val("t5_level_hold", level, 0);
        check_val("t5_rdy_hold", do_rdy, 0);
        repeat (HOLD_CYC) tick();
        check_val("t5_idle_after", dut.state, IDLE);
        check_val("t5_err_sticky", err_acpt, 1);

        // Asynchronous reset while holding with three entries queued.
        for (int i = 0; i < 4; i++) push_word(8'h80 + 8'(i), 2'(i));
        wait_rdy(g);
        accept();
        check_val("t6_hold", dut.state, HOLD);
        check_val("t6_level3", level, 3);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        sb.delete();
        #3;
        rstn = 1'b1;
        tick();
        push_word(8'h9C, 2'b11);
        wait_rdy(g);
        check_val("t6_post_data", do_data, 8'h9C);
        check_val("t6_post_sel", memsel, 2'b11);
        accept();
        repeat (HOLD_CYC + 1) tick();
        check_val("t6_sb_empty", sb.size(), 0);
        check_val("t6_final_idle", dut.state, IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
